// File: rtl/prime_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prime_pkg
//  Brief    : Shared types and constants for the prime sweep controller
//  Revision : 1.0  - initial release
// ============================================================================
package prime_pkg;

   // Width of the swept value range
   localparam int VAL_W = 4;

   // Bit n is set when n is prime (2, 3, 5, 7, 11, 13)
   localparam logic [15:0] PRIME_MASK = 16'b0010_1000_1010_1100;

   // Sweep sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage : prime_pkg
`default_nettype wire

// File: rtl/prime_lut4.sv
`default_nettype none
// ============================================================================
//  Module   : prime_lut4
//  Brief    : Combinational 4-bit prime detector (mask lookup)
//  Revision : 1.0  - initial release
// ============================================================================
module prime_lut4
   import prime_pkg::*;
(
   input  logic [VAL_W-1:0] v,
   output logic             is_prime
);

   // Direct lookup: one mask bit per representable value
   always_comb begin
      is_prime = PRIME_MASK[v];
   end

endmodule : prime_lut4
`default_nettype wire

// File: rtl/prime_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : prime_sweep_ctrl
//  Brief    : Sweeps [lo, hi] through the prime detector one value per cycle,
//             streams primes over valid/ready, counts them, pulses done.
//  Revision : 1.0  - initial release
// ============================================================================
module prime_sweep_ctrl
   import prime_pkg::*;
#(
   parameter int CNT_W = 5
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [VAL_W-1:0] lo,
   input  logic [VAL_W-1:0] hi,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [VAL_W-1:0] out_data,
   output logic             done,
   output logic [CNT_W-1:0] prime_count
);

   state_t           r_state;
   logic [VAL_W-1:0] r_cur;
   logic [VAL_W-1:0] r_hi;
   logic             r_busy;
   logic             r_out_valid;
   logic [VAL_W-1:0] r_out_data;
   logic             r_done;
   logic [CNT_W-1:0] r_count;
   logic             w_is_prime;
   logic             w_at_end;

   // The range start needs no separate register: it lives in r_cur from the
   // accepting edge onwards.
   prime_lut4 u_lut (
      .v        (r_cur),
      .is_prime (w_is_prime)
   );

   // Termination is an equality compare, so hi=15 can never wrap cur to 0
   assign w_at_end = (r_cur == r_hi);

   // Sweep sequencer with registered status and stream outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cur       <= '0;
         r_hi        <= '0;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_done      <= 1'b0;
         r_count     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_hi    <= hi;
                  r_cur   <= lo;
                  r_count <= '0;
                  r_busy  <= 1'b1;
                  if (lo > hi) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (w_is_prime) begin
                  r_out_data  <= r_cur;
                  r_out_valid <= 1'b1;
                  r_state     <= EMIT;
               end else if (w_at_end) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_cur <= r_cur + 1'b1;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (r_count != {CNT_W{1'b1}}) begin
                     r_count <= r_count + 1'b1;
                  end
                  r_out_valid <= 1'b0;
                  if (w_at_end) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_cur   <= r_cur + 1'b1;
                     r_state <= SCAN;
                  end
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign done        = r_done;
   assign prime_count = r_count;

endmodule : prime_sweep_ctrl
`default_nettype wire

// File: tb/tb_prime_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prime_sweep_ctrl
//  Brief    : Scoreboard bench for prime_sweep_ctrl (directed sweeps)
//  Revision : 1.0  - initial release
// ============================================================================
module tb_prime_sweep_ctrl;

   localparam int CNT_W = 5;

   typedef struct {
      int cyc;
      int cnt;
   } done_exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [3:0]       lo;
   logic [3:0]       hi;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       out_data;
   logic             done;
   logic [CNT_W-1:0] prime_count;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   int start_edge = 0;
   int done_cnt = 0;

   logic [3:0] pq[$];
   done_exp_t  dq[$];

   logic       prev_valid = 1'b0;
   logic       prev_ready = 1'b0;
   logic [3:0] prev_data  = '0;

   prime_sweep_ctrl #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .lo          (lo),
      .hi          (hi),
      .busy        (busy),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .done        (done),
      .prime_count (prime_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: stream stability, data order, done timing and count
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (prev_valid && !prev_ready) begin
            check("stall_valid_held", int'(out_valid), 1);
            check("stall_data_held", int'(out_data), int'(prev_data));
         end
         if (out_valid && out_ready) begin
            if (pq.size() == 0) begin
               check("unexpected_out_valid", int'(out_data), -1);
            end else begin
               check("out_data", int'(out_data), int'(pq.pop_front()));
            end
         end
         if (done) begin
            done_cnt++;
            if (dq.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               done_exp_t e;
               e = dq.pop_front();
               check("done_cycle", edge_cnt - start_edge + 1, e.cyc);
               check("done_count", int'(prime_count), e.cnt);
               check("busy_at_done", int'(busy), 1);
            end
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data  = out_data;
      end
   end

   task automatic start_sweep(input logic [3:0] l, input logic [3:0] h);
      @(negedge clk);
      lo         = l;
      hi         = h;
      start      = 1'b1;
      start_edge = edge_cnt + 1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int target;
      bit seen;
      target = done_cnt + 1;
      seen   = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done_cnt >= target) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check({name, "_done_timeout"}, 0, 1);
      @(negedge clk);
      check({name, "_busy_cleared"}, int'(busy), 0);
      check({name, "_primes_left"}, pq.size(), 0);
   endtask

   task automatic push_full();
      pq.push_back(4'd2);  pq.push_back(4'd3);  pq.push_back(4'd5);
      pq.push_back(4'd7);  pq.push_back(4'd11); pq.push_back(4'd13);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      rst       = 1'b1;
      start     = 1'b0;
      lo        = '0;
      hi        = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_valid", int'(out_valid), 0);
      check("reset_data", int'(out_data), 0);
      check("reset_done", int'(done), 0);
      check("reset_count", int'(prime_count), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Full sweep 0..15: 16 values + 6 primes
      push_full();
      dq.push_back('{cyc: 23, cnt: 6});
      start_sweep(4'd0, 4'd15);
      wait_done("full");
      check("count_holds_idle", int'(prime_count), 6);

      // Reference run 2..3 without stall
      pq.push_back(4'd2); pq.push_back(4'd3);
      dq.push_back('{cyc: 5, cnt: 2});
      start_sweep(4'd2, 4'd3);
      wait_done("nostall");

      // Backpressure: 4 stalled cycles on the first prime
      out_ready = 1'b0;
      pq.push_back(4'd2); pq.push_back(4'd3);
      dq.push_back('{cyc: 9, cnt: 2});
      start_sweep(4'd2, 4'd3);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("bp_valid_seen", int'(found), 1);
      check("bp_first_data", int'(out_data), 2);
      repeat (4) @(negedge clk);
      out_ready = 1'b1;
      wait_done("stall");

      // Empty and degenerate ranges
      dq.push_back('{cyc: 1, cnt: 0});
      start_sweep(4'd9, 4'd4);
      wait_done("empty");
      dq.push_back('{cyc: 2, cnt: 0});
      start_sweep(4'd4, 4'd4);
      wait_done("single_nonprime");
      pq.push_back(4'd13);
      dq.push_back('{cyc: 3, cnt: 1});
      start_sweep(4'd13, 4'd13);
      wait_done("single_prime");

      // Start while busy is ignored
      push_full();
      dq.push_back('{cyc: 23, cnt: 6});
      start_sweep(4'd0, 4'd15);
      repeat (5) @(negedge clk);
      check("busy_mid_sweep", int'(busy), 1);
      lo    = 4'd0;
      hi    = 4'd15;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_start");

      // Reset while holding prime 5
      pq.push_back(4'd2); pq.push_back(4'd3); pq.push_back(4'd5);
      start_sweep(4'd0, 4'd15);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid && out_data == 4'd5) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rst_emit5_seen", int'(found), 1);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_valid", int'(out_valid), 0);
      check("rst_mid_count", int'(prime_count), 0);
      check("rst_mid_done", int'(done), 0);
      check("rst_mid_primes_left", pq.size(), 0);
      repeat (3) @(negedge clk);
      push_full();
      dq.push_back('{cyc: 23, cnt: 6});
      start_sweep(4'd0, 4'd15);
      wait_done("after_rst");

      repeat (3) @(negedge clk);
      check("final_done_queue", dq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_prime_sweep_ctrl
`default_nettype wire

// File: doc/prime_sweep_ctrl.md
Name: prime_sweep_ctrl

Overview:
- Sequencer that sweeps a 4-bit value range [lo, hi] through the combinational prime detector, one value per cycle.
- Streams each prime found out over a valid/ready handshake, counts the primes, and signals completion.
- Sits between a host or bench driver and the prime datapath. Replaces free-running stimulus loops with a deterministic start/busy/done controller.

Parameters:
- CNT_W, 5, width of prime_count. Must be ≥3; a full 0..15 sweep yields 6.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a sweep; sampled only in IDLE
- lo  input  4  first value of the range, inclusive; latched on an accepted start
- hi  input  4  last value of the range, inclusive; latched on an accepted start
- busy  output  1  high from the cycle after an accepted start through the DONE cycle
- out_valid  output  1  out_data holds a prime
- out_ready  input  1  downstream accepts out_data
- out_data  output  4  prime value
- done  output  1  single-cycle pulse at the end of a sweep
- prime_count  output  CNT_W  number of primes accepted in the current or last sweep

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE, busy=0, out_valid=0, out_data=0, done=0, prime_count=0, internal cur/lo/hi registers=0.
- Reset mid-sweep aborts immediately. No done pulse. Any pending out_valid is dropped.
- Registered outputs: busy, out_valid, out_data, done, prime_count.
- IDLE:
  - start=1 → latch lo_r=lo, hi_r=hi, cur=lo, prime_count=0.
  - If lo>hi, next state is DONE (empty range). Otherwise next state is SCAN.
  - start while busy is ignored.
- SCAN: the detector sees cur (combinational, same cycle).
  - is_prime=1 → out_data<=cur, out_valid<=1, go to EMIT.
  - is_prime=0 and cur==hi_r → go to DONE.
  - is_prime=0 otherwise → cur<=cur+1, stay in SCAN.
- EMIT:
  - out_valid and out_data are held stable until out_valid&&out_ready.
  - On handshake: prime_count+=1, out_valid<=0.
  - Then, if cur==hi_r, go to DONE; else cur<=cur+1 and go to SCAN.
  - out_ready is ignored when out_valid=0.
- DONE: done=1 for exactly one cycle, busy=1, next state is IDLE. prime_count holds until the next accepted start.
- Wrap-around: termination is the compare cur==hi_r, never a carry. hi=15 must not wrap cur to 0 or loop forever. The cur increment is never performed when cur==hi_r.
- Timing: with a start sampled at edge 0 and out_ready held at 1, done is high in cycle 1+N+P, where N=hi-lo+1 and P=number of primes in range. Each stalled cycle on out_ready adds one cycle.
- prime_count saturates at its maximum. Unreachable for 4-bit values, but the requirement stands.
- Primes in 0..15: 2, 3, 5, 7, 11, 13. Values 0 and 1 are not prime.

Decomposition:
- Shared package prime_pkg:
  - state enum {IDLE, SCAN, EMIT, DONE}, 2 bits
  - constant VAL_W=4
  - constant PRIME_MASK=16'b0010_1000_1010_1100 (bit n set ⇔ n is prime)
- Sub-module prime_lut4 (combinational): input [3:0] v, output is_prime = PRIME_MASK[v]. Instantiated once. Verifiable on its own by exhaustive check.

Test Plan:
- Full sweep: lo=0, hi=15, out_ready=1, start pulse → out_data sequence 2,3,5,7,11,13; done in cycle 23 after start; prime_count=6; no wrap (cur never returns to 0).
- Backpressure: lo=2, hi=3, out_ready=0 for 4 cycles then 1 → out_data=2 held stable with out_valid=1 throughout the stall, then 3; prime_count=2; done delayed by exactly 4 cycles versus the no-stall run.
- Empty/degenerate ranges:
  - lo=9, hi=4 → done in cycle 1, prime_count=0, no out_valid.
  - lo=hi=4 → done in cycle 2, count=0.
  - lo=hi=13 → one emit of 13, count=1.
- Start while busy: second start pulse with lo=0 during a 0..15 sweep → ignored; results identical to the full-sweep case; start accepted again only after done.
- Reset mid-sweep: rst=1 one cycle while in EMIT holding 5 → next cycle busy=0, out_valid=0, prime_count=0, no done; a fresh start 0..15 then completes normally with count=6.
